// File: rtl/fifo_pkg.sv
// Shared types and default widths for the FIFO reader.
package fifo_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int CNT_WIDTH_DEF  = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } rd_state_t;

endpackage

// File: rtl/reader_skid_buf.sv
// Two-entry FIFO-ordered skid buffer holding words returned by the FIFO
// until the downstream stream accepts them. Clear has priority over push/pop.
module reader_skid_buf
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  clear,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [1:0]            occ,
  output logic [DATA_WIDTH-1:0] head
);

  logic [DATA_WIDTH-1:0] slot0_p1;
  logic [DATA_WIDTH-1:0] slot1_p1;
  logic [1:0]            occ_p1;

  // Stage 1: words land here one cycle after the FIFO returns them
  // Slot 0 is always the head; slot 1 shifts forward when the head is taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_p1   <= 2'd0;
      slot0_p1 <= '0;
      slot1_p1 <= '0;
    end else if (clear) begin
      occ_p1 <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (occ_p1 == 2'd0) slot0_p1 <= din;
          else                slot1_p1 <= din;
          occ_p1 <= occ_p1 + 2'd1;
        end
        2'b01: begin
          slot0_p1 <= slot1_p1;
          occ_p1   <= occ_p1 - 2'd1;
        end
        2'b11: begin
          if (occ_p1 == 2'd2) begin
            slot0_p1 <= slot1_p1;
            slot1_p1 <= din;
          end else begin
            slot0_p1 <= din;
          end
        end
        default: ;
      endcase
    end
  end

  assign occ  = occ_p1;
  assign head = slot0_p1;

endmodule

// File: rtl/fifo_reader.sv
// Drains a show-ahead-less FIFO (data one cycle after RD) into a valid/ready
// stream through a 2-entry skid buffer, with a flush that discards everything.
// Optional statistics counters are compiled in with FIFO_READER_STATS_EN.
module fifo_reader
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int CNT_WIDTH  = CNT_WIDTH_DEF
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic                  enable,
  input  logic                  flush,
  input  logic                  EMPTY,
  input  logic [DATA_WIDTH-1:0] dataOut,
  output logic                  RD,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  output logic                  flush_done,
  output logic                  busy
`ifdef FIFO_READER_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0]  word_cnt,
  output logic [CNT_WIDTH-1:0]  stall_cnt
`endif
);

  rd_state_t state, state_nxt;
  logic      rd_pend;
  logic [1:0] occ;
  logic      pop;
  logic      push;
  logic [2:0] fill_nxt;

  assign m_valid  = (occ != 2'd0);
  assign pop      = m_valid & m_ready;
  assign push     = rd_pend & (state == ST_RUN);
  // Words the buffer will hold once the outstanding read lands and this
  // cycle's pop is taken; a new read is only safe if that leaves a free slot.
  assign fill_nxt = {1'b0, occ} + {2'b00, rd_pend} - {2'b00, pop};
  assign busy     = (state != ST_IDLE) || (occ != 2'd0);

  // State register and read-in-flight marker
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state   <= ST_IDLE;
      rd_pend <= 1'b0;
    end else begin
      state   <= state_nxt;
      rd_pend <= RD;
    end
  end

  // Next-state, FIFO pop strobe and flush completion
  always_comb begin
    state_nxt  = state;
    RD         = 1'b0;
    flush_done = 1'b0;
    case (state)
      ST_IDLE: begin
        if (enable) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        RD = enable && !EMPTY && (fill_nxt < 3'd2);
        if (!enable && !rd_pend) state_nxt = ST_IDLE;
      end
      ST_FLUSH: begin
        RD = !EMPTY;
        if (EMPTY && !rd_pend) begin
          flush_done = !flush;
          state_nxt  = enable ? ST_RUN : ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (flush) state_nxt = ST_FLUSH;
  end

  // Stage 0 -> 1: FIFO read data enters the skid buffer
  reader_skid_buf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_skid (
    .clk  (Clk),
    .rst_n(Rst_n),
    .push (push),
    .pop  (pop),
    .clear(flush),
    .din  (dataOut),
    .occ  (occ),
    .head (m_data)
  );

`ifdef FIFO_READER_STATS_EN
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Transfer counter wraps; stall counter sticks at all-ones
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      word_cnt  <= '0;
      stall_cnt <= '0;
    end else begin
      if (pop) word_cnt <= word_cnt + 1'b1;
      if ((state == ST_RUN) && m_ready && !m_valid) stall_cnt <= sat_inc(stall_cnt);
    end
  end
`else
  logic unused_cnt_w;
  assign unused_cnt_w = (CNT_WIDTH > 0);
`endif

endmodule

// File: tb/tb_fifo_reader.sv
// Scoreboard bench for fifo_reader: a queue-based FIFO model feeds the DUT,
// expected stream words are queued at issue time and a monitor pops/compares.
module tb_fifo_reader;

  localparam int DW = 8;
  localparam int CW = 16;

  logic          Clk = 1'b0;
  logic          Rst_n;
  logic          enable;
  logic          flush;
  logic          EMPTY = 1'b1;
  logic [DW-1:0] dataOut = '0;
  logic          RD;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_ready;
  logic          flush_done;
  logic          busy;
`ifdef FIFO_READER_STATS_EN
  logic [CW-1:0] word_cnt;
  logic [CW-1:0] stall_cnt;
`endif

  always #5 Clk = ~Clk;

  fifo_reader #(
    .DATA_WIDTH(DW),
    .CNT_WIDTH (CW)
  ) dut (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .enable    (enable),
    .flush     (flush),
    .EMPTY     (EMPTY),
    .dataOut   (dataOut),
    .RD        (RD),
    .m_valid   (m_valid),
    .m_data    (m_data),
    .m_ready   (m_ready),
    .flush_done(flush_done),
    .busy      (busy)
`ifdef FIFO_READER_STATS_EN
    ,
    .word_cnt  (word_cnt),
    .stall_cnt (stall_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] exp_q[$];
  logic rd_smp = 1'b0;
  int   fd_cnt = 0;
  int   xfer_total = 0;
  int   outst = 0;
  logic chk_occ = 1'b0;
  logic flush_phase = 1'b0;
  logic prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  task automatic push_word(input logic [DW-1:0] w, input bit expect_out);
    fifo_q.push_back(w);
    if (expect_out) exp_q.push_back(w);
    EMPTY = 1'b0;
  endtask

  task automatic wait_drain(input int lim);
    int n = 0;
    while (exp_q.size() != 0 && n < lim) begin
      @(negedge Clk);
      n++;
    end
    check("stream drained", exp_q.size(), 0);
  endtask

  task automatic wait_flush_done(input int fd0);
    int n = 0;
    while (fd_cnt == fd0 && n < 60) begin
      @(negedge Clk);
      n++;
    end
    repeat (10) @(negedge Clk);
    check("flush_done pulses", fd_cnt - fd0, 1);
    check("fifo emptied by flush", fifo_q.size(), 0);
    check("idle after flush", busy, 0);
  endtask

  // FIFO model: data appears the cycle after RD is sampled
  always @(posedge Clk) begin
    if (rd_smp) begin
      check("rd while empty", fifo_q.size() == 0, 0);
      if (fifo_q.size() != 0) dataOut <= fifo_q.pop_front();
    end
    EMPTY = (fifo_q.size() == 0);
  end

  // Monitor: stream order, stall stability, occupancy bound, flush_done pulses
  always @(negedge Clk) begin
    rd_smp = RD;
    if (!Rst_n) begin
      prev_stall = 1'b0;
      outst      = 0;
      xfer_total = 0;
    end else begin
      if (chk_occ) begin
        check("words held or in flight <= 2", outst <= 2, 1);
        outst = outst + (RD ? 1 : 0) - ((m_valid && m_ready) ? 1 : 0);
      end else begin
        outst = 0;
      end
      if (prev_stall && !flush_phase) begin
        check("valid held while stalled", m_valid, 1);
        check("data stable while stalled", m_data, prev_data);
      end
      if (flush_done) fd_cnt++;
      if (m_valid && m_ready) begin
        xfer_total++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected word: got %0h expected none", m_data);
        end else begin
          check("stream data", m_data, exp_q.pop_front());
        end
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: got no finish expected finish within limit");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int fd0;
    Rst_n = 1'b0; enable = 1'b0; flush = 1'b0; m_ready = 1'b0;
    repeat (3) @(negedge Clk);
    check("reset RD", RD, 0);
    check("reset m_valid", m_valid, 0);
    check("reset m_data", m_data, 0);
    check("reset flush_done", flush_done, 0);
    check("reset busy", busy, 0);
`ifdef FIFO_READER_STATS_EN
    check("reset word_cnt", word_cnt, 0);
    check("reset stall_cnt", stall_cnt, 0);
`endif
    @(posedge Clk); #1 Rst_n = 1'b1; chk_occ = 1'b1;

    // Empty FIFO with reader enabled: no reads, stalls counted
    enable = 1'b1; m_ready = 1'b1;
    @(posedge Clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      check("RD while EMPTY", RD, 0);
      check("no valid while EMPTY", m_valid, 0);
      @(posedge Clk);
    end
`ifdef FIFO_READER_STATS_EN
    @(negedge Clk);
    check("stall_cnt after 10 RUN cycles", stall_cnt, 10);
`endif
    @(posedge Clk); #1 enable = 1'b0;
    repeat (3) @(posedge Clk); #1;

    // Preloaded 0x00..0x0F, full-rate drain
    for (int w = 0; w < 16; w++) push_word(DW'(w), 1'b1);
    enable = 1'b1; m_ready = 1'b1;
    n = 0;
    @(negedge Clk);
    while (!RD && n < 10) begin
      @(negedge Clk);
      n++;
    end
    check("first RD seen", RD, 1);
    n = 0;
    do begin
      @(negedge Clk);
      n++;
    end while (!m_valid && n < 10);
    check("RD to m_valid latency", n, 2);
    for (int i = 1; i < 16; i++) begin
      @(negedge Clk);
      check("no bubble in stream", m_valid, 1);
    end
    wait_drain(20);
    @(posedge Clk); #1 enable = 1'b0;
    repeat (3) @(posedge Clk); #1;

    // Same preload with m_ready toggling
    for (int w = 0; w < 16; w++) push_word(DW'(w), 1'b1);
    enable = 1'b1;
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) begin
      @(posedge Clk); #1 m_ready = ~m_ready;
    end
    m_ready = 1'b1;
    wait_drain(20);

    // Random pushes, back-pressure and enable toggling
    for (int i = 0; i < 400; i++) begin
      @(posedge Clk); #1;
      if ($urandom_range(0, 2) != 0) push_word(DW'($urandom_range(0, 255)), 1'b1);
      m_ready = ($urandom_range(0, 9) < 6);
      if ($urandom_range(0, 19) == 0) enable = ~enable;
    end
    @(posedge Clk); #1 enable = 1'b1; m_ready = 1'b1;
    wait_drain(800);
    @(posedge Clk); #1 enable = 1'b0;
    repeat (3) @(posedge Clk); #1;
`ifdef FIFO_READER_STATS_EN
    check("word_cnt vs transfers", word_cnt, CW'(xfer_total));
`endif

    // Flush pulse mid-stream
    chk_occ = 1'b0; flush_phase = 1'b1;
    for (int w = 0; w < 8; w++) push_word(DW'($urandom_range(0, 255)), 1'b1);
    enable = 1'b1; m_ready = 1'b1;
    n = 0;
    while (exp_q.size() > 5 && n < 20) begin
      @(negedge Clk);
      n++;
    end
    check("words before flush", exp_q.size() <= 5, 1);
    @(posedge Clk); #1 flush = 1'b1; m_ready = 1'b0; enable = 1'b0;
    exp_q.delete();
    fd0 = fd_cnt;
    @(posedge Clk); #1 flush = 1'b0; m_ready = 1'b1;
    @(negedge Clk);
    check("m_valid cycle after flush", m_valid, 0);
    wait_flush_done(fd0);

    // Flush held over several cycles, including past the drain point
    for (int w = 0; w < 8; w++) push_word(DW'($urandom_range(0, 255)), 1'b0);
    @(posedge Clk); #1 enable = 1'b1; m_ready = 1'b0;
    repeat (6) @(posedge Clk);
    #1 flush = 1'b1; enable = 1'b0;
    fd0 = fd_cnt;
    repeat (12) @(posedge Clk);
    #1 flush = 1'b0; m_ready = 1'b1;
    wait_flush_done(fd0);
    flush_phase = 1'b0;
    @(posedge Clk); #1 chk_occ = 1'b1;

    // Asynchronous reset with two words buffered
    for (int w = 0; w < 6; w++) push_word(DW'(8'hA0 + w), 1'b0);
    enable = 1'b1; m_ready = 1'b0;
    repeat (6) @(posedge Clk);
    @(negedge Clk);
    check("buffered before reset", m_valid, 1);
    @(posedge Clk); #2 chk_occ = 1'b0; Rst_n = 1'b0;
    #1;
    check("async reset m_valid", m_valid, 0);
    check("async reset RD", RD, 0);
    check("async reset busy", busy, 0);
    check("async reset m_data", m_data, 0);
    enable = 1'b0; m_ready = 1'b1;
    @(posedge Clk); #1 Rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      check("no output before enable", m_valid, 0);
    end
    check("fifo words kept across reset", fifo_q.size(), 4);
    exp_q = fifo_q;
    @(posedge Clk); #1 enable = 1'b1; chk_occ = 1'b1;
    wait_drain(50);
`ifdef FIFO_READER_STATS_EN
    check("word_cnt after reset", word_cnt, CW'(xfer_total));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
